// File: rtl/fp16_normalize_pack_pkg.sv
// Shared widths, constants and the round/pack helper for the fp16 normalize/pack pipeline.
// Subnormal support is selected at build time with FP16_PACK_SUBNORMAL_EN.
package fp16_pkg;

    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int GRS_W   = 3;
    localparam int MAG_W   = 14;
    localparam int BIAS    = 15;
    localparam int EXP_MAX = 31;

    localparam logic [15:0] POS_INF = 16'h7C00;
    localparam logic [15:0] NEG_INF = 16'hFC00;

    typedef struct packed {
        logic               sign;
        logic [EXP_W:0]     exp;
        logic [MAG_W-1:0]   mag;
        logic               isInf;
        logic               isZero;
    } s1_t;

    // mag holds the aligned significand: [13] hidden, [12:3] mantissa, [2:0] guard/round/sticky.
    // A clear hidden bit after rounding means the value is subnormal, so the exponent field becomes 0.
    function automatic logic [15:0] roundPack(input logic sign,
                                              input logic [EXP_W:0] exp,
                                              input logic [MAG_W-1:0] mag);
        logic             inc;
        logic [MAN_W+1:0] sum;
        logic [EXP_W:0]   expOut;
        logic [MAN_W-1:0] man;
        inc = mag[GRS_W-1] & (mag[GRS_W-2] | mag[0] | mag[GRS_W]);
        sum = {1'b0, mag[MAG_W-1:GRS_W]} + {{(MAN_W+1){1'b0}}, inc};
        man = sum[MAN_W-1:0];
        if (sum[MAN_W+1]) begin
            expOut = exp + 6'd1;
        end else if (sum[MAN_W]) begin
            expOut = exp;
        end else begin
            expOut = '0;
        end
        if (expOut >= (EXP_W+1)'(EXP_MAX)) begin
            return sign ? NEG_INF : POS_INF;
        end
        return {sign, expOut[EXP_W-1:0], man};
    endfunction

endpackage

// File: rtl/fp16_normalize_pack_if.sv
// Upstream sum / downstream fp16 handshake bundle for fp16_normalize_pack.
interface fp16_normalize_pack_if;
    import fp16_pkg::*;

    logic               i_valid;
    logic               o_ready;
    logic               i_sign;
    logic [EXP_W-1:0]   i_exp;
    logic [MAG_W-1:0]   i_magnitude;
    logic               i_overflow;
    logic               o_valid;
    logic               i_ready;
    logic [15:0]        o_fp16;

    modport slave (
        input  i_valid, i_sign, i_exp, i_magnitude, i_overflow, i_ready,
        output o_ready, o_valid, o_fp16
    );

    modport master (
        output i_valid, i_sign, i_exp, i_magnitude, i_overflow, i_ready,
        input  o_ready, o_valid, o_fp16
    );

endinterface

// File: rtl/fp16_normalize_pack_lzc.sv
// Combinational leading-zero counter over the 14-bit sum magnitude; an all-zero input counts 14.
module fp16_lzc
    import fp16_pkg::*;
(
    input  logic [MAG_W-1:0] in_i,
    output logic [3:0]       count_o
);

    always_comb begin
        count_o = 4'(MAG_W);
        for (int i = 0; i < MAG_W; i++) begin
            if (in_i[i]) begin
                count_o = 4'(MAG_W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/fp16_normalize_pack.sv
// Two-stage normalize (carry/LZC/shift) and round/pack of a sign-magnitude sum into IEEE binary16.
// Define FP16_PACK_SUBNORMAL_EN to emit subnormals instead of flushing underflow to signed zero.
module fp16_normalize_pack
    import fp16_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    fp16_normalize_pack_if.slave  bus
);

    logic [3:0]       lzc;
    logic [EXP_W-1:0] limit;
    logic [EXP_W-1:0] shift;
    logic             underflow;
    logic             advance;

    s1_t              s1_d;
    s1_t              s1_q;
    logic             s1Valid_q;
    logic             s2Valid_q;
    logic [15:0]      fp16_d;
    logic [15:0]      fp16_q;

    fp16_lzc uLzc (
        .in_i    (bus.i_magnitude),
        .count_o (lzc)
    );

    assign advance     = !s2Valid_q || bus.i_ready;
    assign bus.o_ready = advance;
    assign bus.o_valid = s2Valid_q;
    assign bus.o_fp16  = fp16_q;

    // Normalizing left shift may not push the exponent below 1; underflow marks that clamp.
    always_comb begin
        s1_d      = '0;
        s1_d.sign = bus.i_sign;
        limit     = (bus.i_exp == '0) ? '0 : bus.i_exp - 5'd1;
        underflow = {1'b0, lzc} > limit;
        shift     = underflow ? limit : {1'b0, lzc};
        if (bus.i_exp == 5'(EXP_MAX)) begin
            s1_d.isInf = 1'b1;
        end else if (bus.i_overflow) begin
            s1_d.mag    = {1'b1, bus.i_magnitude[MAG_W-1:1]};
            s1_d.mag[0] = bus.i_magnitude[1] | bus.i_magnitude[0];
            s1_d.exp    = {1'b0, bus.i_exp} + 6'd1;
        end else if (bus.i_magnitude == '0) begin
            s1_d.isZero = 1'b1;
        end else begin
`ifdef FP16_PACK_SUBNORMAL_EN
            s1_d.mag = bus.i_magnitude << shift;
            s1_d.exp = {1'b0, bus.i_exp - shift};
`else
            if (underflow) begin
                s1_d.isZero = 1'b1;
            end else begin
                s1_d.mag = bus.i_magnitude << shift;
                s1_d.exp = {1'b0, bus.i_exp - shift};
            end
`endif
        end
    end

    always_comb begin
        fp16_d = roundPack(s1_q.sign, s1_q.exp, s1_q.mag);
        if (s1_q.isInf) begin
            fp16_d = s1_q.sign ? NEG_INF : POS_INF;
        end else if (s1_q.isZero) begin
            fp16_d = {s1_q.sign, 15'h0};
        end
    end

    // Both stages move together only when the output slot is free or being drained.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1Valid_q <= 1'b0;
            s1_q      <= '0;
            s2Valid_q <= 1'b0;
            fp16_q    <= '0;
        end else if (advance) begin
            s1Valid_q <= bus.i_valid;
            if (bus.i_valid) begin
                s1_q <= s1_d;
            end
            s2Valid_q <= s1Valid_q;
            if (s1Valid_q) begin
                fp16_q <= fp16_d;
            end
        end
    end

endmodule

// File: tb/tb_fp16_normalize_pack.sv
// Self-checking bench for fp16_normalize_pack: exact-value RNE model, scoreboard and directed vectors.
module tb_fp16_normalize_pack;
    import fp16_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp16_normalize_pack_if bus ();

    fp16_normalize_pack dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [15:0] expQ[$];
    logic [15:0] gotQ[$];
    bit tableRun;

    typedef struct {
        bit          s;
        logic [4:0]  e;
        logic [13:0] m;
        bit          o;
        logic [15:0] want;
    } vec_t;

`ifdef FP16_PACK_SUBNORMAL_EN
    localparam logic [15:0] SUB1 = 16'h0200;
    localparam logic [15:0] SUB2 = 16'h0400;
    localparam logic [15:0] SUB3 = 16'h0080;
`else
    localparam logic [15:0] SUB1 = 16'h0000;
    localparam logic [15:0] SUB2 = 16'h0000;
    localparam logic [15:0] SUB3 = 16'h0000;
`endif

    vec_t tbl[18] = '{
        '{1'b0, 5'd15, 14'h2000, 1'b0, 16'h3C00},
        '{1'b0, 5'd15, 14'h0000, 1'b1, 16'h4000},
        '{1'b0, 5'd15, 14'h0008, 1'b0, 16'h1400},
        '{1'b0, 5'd15, 14'h2004, 1'b0, 16'h3C00},
        '{1'b0, 5'd15, 14'h200C, 1'b0, 16'h3C02},
        '{1'b0, 5'd30, 14'h0000, 1'b1, 16'h7C00},
        '{1'b1, 5'd30, 14'h0000, 1'b1, 16'hFC00},
        '{1'b0, 5'd1,  14'h1000, 1'b0, SUB1},
        '{1'b1, 5'd20, 14'h0000, 1'b0, 16'h8000},
        '{1'b0, 5'd31, 14'h2000, 1'b0, 16'h7C00},
        '{1'b0, 5'd15, 14'h3FFC, 1'b0, 16'h4000},
        '{1'b0, 5'd30, 14'h3FFC, 1'b0, 16'h7C00},
        '{1'b0, 5'd15, 14'h000C, 1'b1, 16'h4001},
        '{1'b0, 5'd15, 14'h0018, 1'b1, 16'h4002},
        '{1'b0, 5'd1,  14'h1FFC, 1'b0, SUB2},
        '{1'b0, 5'd3,  14'h0100, 1'b0, SUB3},
        '{1'b0, 5'd6,  14'h0100, 1'b0, 16'h0400},
        '{1'b1, 5'd16, 14'h3000, 1'b0, 16'hC200}
    };

    // Value = v * 2^(e-28); round it to the binary16 quantum of its binade (2^-24 floor) with RNE.
    function automatic logic [15:0] modelPack(bit s, int e, int mag, bit ovf);
        int v, p, be, eff, sh, q, rem, half, bits;
        if (e == 31) return {s, 15'h7C00};
        v = ovf ? (mag + 16384) : mag;
        if (v == 0) return {s, 15'h0};
        p = 0;
        for (int i = 0; i < 15; i++) begin
            if (((v >> i) & 1) == 1) p = i;
        end
        be = e + p - 13;
`ifndef FP16_PACK_SUBNORMAL_EN
        if (be < 1) return {s, 15'h0};
`endif
        eff = (be < 1) ? 1 : be;
        sh  = eff - e + 3;
        if (sh > 0) begin
            q    = v >> sh;
            rem  = v - (q << sh);
            half = 1 << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
        end else begin
            q = v << (-sh);
        end
        bits = (eff - 1) * 1024 + q;
        if (bits >= 32'h7C00) return {s, 15'h7C00};
        return {s, 15'(bits)};
    endfunction

    task automatic check16(string name, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check1(string name, logic act, logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    // Scoreboard: outputs must match the model in acceptance order, ready must follow the stall rule.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
        end else begin
            check1("o_ready_rule", bus.o_ready, !bus.o_valid || bus.i_ready);
            if (bus.o_valid && bus.i_ready) begin
                gotQ.push_back(bus.o_fp16);
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_output actual=%h required=none", bus.o_fp16);
                end else begin
                    check16("scoreboard", bus.o_fp16, expQ.pop_front());
                end
            end
            if (bus.i_valid && bus.o_ready) begin
                expQ.push_back(modelPack(bus.i_sign, int'(bus.i_exp), int'(bus.i_magnitude), bus.i_overflow));
            end
        end
    end

    task automatic sendInput(bit s, logic [4:0] e, logic [13:0] m, bit o);
        int guard = 0;
        bus.i_valid     = 1'b1;
        bus.i_sign      = s;
        bus.i_exp       = e;
        bus.i_magnitude = m;
        bus.i_overflow  = o;
        @(negedge clk);
        while (!bus.o_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout actual=stalled required=accept");
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic applyStimulus(string name, bit s, logic [4:0] e, logic [13:0] m, bit o, logic [15:0] want);
        check16({name, "_model"}, modelPack(s, int'(e), int'(m), o), want);
        @(posedge clk);
        #1;
        sendInput(s, e, m, o);
        @(negedge clk);
        check1({name, "_early_valid"}, bus.o_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check1({name, "_valid"}, bus.o_valid, 1'b1);
        check16(name, bus.o_fp16, want);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int g = 0;
        while (expQ.size() != 0 && g < 200) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain_timeout actual=%0d pending required=0", expQ.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst             = 1'b1;
        bus.i_valid     = 1'b0;
        bus.i_sign      = 1'b0;
        bus.i_exp       = '0;
        bus.i_magnitude = '0;
        bus.i_overflow  = 1'b0;
        bus.i_ready     = 1'b1;
        repeat (2) @(negedge clk);
        check1("reset_o_valid", bus.o_valid, 1'b0);
        check16("reset_o_fp16", bus.o_fp16, 16'h0000);
        check1("reset_o_ready", bus.o_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        applyStimulus("one", 1'b0, 5'd15, 14'h2000, 1'b0, 16'h3C00);
        applyStimulus("cancel", 1'b0, 5'd15, 14'h0008, 1'b0, 16'h1400);
        applyStimulus("neg_inf", 1'b1, 5'd30, 14'h0000, 1'b1, 16'hFC00);

        // Table vectors streamed back to back while downstream readiness wanders.
        tableRun = 1'b1;
        fork
            begin
                foreach (tbl[i]) begin
                    check16("model_pin", modelPack(tbl[i].s, int'(tbl[i].e), int'(tbl[i].m), tbl[i].o), tbl[i].want);
                    sendInput(tbl[i].s, tbl[i].e, tbl[i].m, tbl[i].o);
                end
                tableRun = 1'b0;
            end
            begin
                while (tableRun) begin
                    @(posedge clk);
                    #1;
                    if (tableRun) bus.i_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.i_ready = 1'b1;
        drain();

        gotQ.delete();
        fork
            begin
                sendInput(1'b0, 5'd15, 14'h2000, 1'b0);
                sendInput(1'b0, 5'd16, 14'h2000, 1'b0);
                sendInput(1'b0, 5'd17, 14'h2000, 1'b0);
            end
            begin
                @(posedge clk);
                #1;
                @(posedge clk);
                #1;
                bus.i_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check1("stall_o_ready", bus.o_ready, 1'b0);
                end
                @(posedge clk);
                #1;
                bus.i_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (gotQ.size() != 3) begin
            failures++;
            $display("[TB] FAIL stall_count actual=%0d required=3", gotQ.size());
        end else begin
            check16("stall_order0", gotQ[0], 16'h3C00);
            check16("stall_order1", gotQ[1], 16'h4000);
            check16("stall_order2", gotQ[2], 16'h4400);
        end

        sendInput(1'b0, 5'd15, 14'h2000, 1'b0);
        sendInput(1'b0, 5'd16, 14'h2000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check1("midreset_o_valid", bus.o_valid, 1'b0);
        check16("midreset_o_fp16", bus.o_fp16, 16'h0000);
        check1("midreset_o_ready", bus.o_ready, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check1("midreset_no_output", bus.o_valid, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp16_normalize_pack.md
FP16_NORMALIZE_PACK -- requirements
Module: fp16_normalize_pack

Interface
REQ-001 Parameters: none; all widths come from fp16_pkg.
REQ-002 Clocking: one clock; reset is asynchronous and active-high.
REQ-003 i_clk  in  1  rising-edge clock.
REQ-004 i_rst  in  1  asynchronous active-high reset.
REQ-005 i_valid  in  1  upstream sum valid.
REQ-006 o_ready  out  1  block accepts the sum this cycle.
REQ-007 i_sign  in  1  sign of the sign-magnitude sum.
REQ-008 i_exp  in  5  biased exponent of the larger operand, range 1..30.
REQ-009 i_magnitude  in  14  sum magnitude: [13] hidden, [12:3] mantissa, [2] guard, [1] round, [0] sticky.
REQ-010 i_overflow  in  1  carry out of the magnitude add, weight 2^14.
REQ-011 o_valid  out  1  o_fp16 holds a result.
REQ-012 i_ready  in  1  downstream accepts o_fp16.
REQ-013 o_fp16  out  16  IEEE binary16 result.

Function
REQ-014 Transfers SHALL occur on a cycle with valid&ready at either port.
REQ-015 Pipeline SHALL have two stages: S1 = carry/LZC/shift, S2 = round/pack; latency is 2 cycles from input accept to o_valid.
REQ-016 Stall rule: o_ready = !o_valid || i_ready; when o_ready=0, both stages hold.
REQ-017 Throughput SHALL be one result per cycle when i_ready=1; order is preserved, with no loss or duplication.
REQ-018 If i_overflow=1: magnitude = {1, i_magnitude[13:1]}, sticky |= i_magnitude[0], exp = i_exp+1.
REQ-019 Otherwise: left-shift by the leading-zero count of i_magnitude and set exp = i_exp - lzc, with the shift limited so exp >= 1.
REQ-020 Zero input (magnitude 0, no overflow) SHALL give o_fp16 = {i_sign, 15'h0}.
REQ-021 Rounding SHALL be round-to-nearest-even: increment when G & (R | S | mant_lsb).
REQ-022 A rounding carry out of the mantissa SHALL set mantissa 0 and exp+1.
REQ-023 A final exp >= 31 SHALL give ±infinity ({sign, 5'h1F, 10'h0}).
REQ-024 i_exp = 31 on input SHALL produce ±infinity.
REQ-025 Normal results: o_fp16 = {sign, exp[4:0], mantissa[9:0]}.

Reset
REQ-026 Reset SHALL clear o_valid, all stage valids and o_fp16 to 0.
REQ-027 o_ready SHALL read 1 during and after reset.
REQ-028 Reset mid-operation SHALL discard in-flight results; no output appears for them.

Configuration
REQ-029 Macro FP16_PACK_SUBNORMAL_EN SHALL select subnormal handling.
REQ-030 With the macro defined: when the required exponent is < 1, the block right-aligns to exp 1, rounds, and emits exp field 0 (subnormal); a rounding carry into bit 10 yields exp 1.
REQ-031 Without the macro: any result with required exponent < 1 SHALL flush to {sign, 15'h0}.

Structure
REQ-032 fp16_pkg SHALL hold EXP_W=5, MAN_W=10, GRS_W=3, MAG_W=14, BIAS=15, EXP_MAX=31, and constants POS_INF=16'h7C00, NEG_INF=16'hFC00.
REQ-033 Leading-zero count SHALL be a sub-module fp16_lzc: 14-bit input, 4-bit count, combinational, instantiated in S1.

Verification
REQ-034 i_exp=15, mag=14'h2000, ovf=0 -> o_fp16=16'h3C00 two cycles after accept.
REQ-035 i_exp=15, mag=14'h0000, ovf=1 -> 16'h4000; i_exp=15, mag=14'h0008 -> 16'h1400 (cancellation).
REQ-036 RNE: mag=14'h2004, exp 15 -> 16'h3C00 (tie, even); mag=14'h200C -> 16'h3C02.
REQ-037 i_exp=30, ovf=1, sign=0 -> 16'h7C00; same with sign=1 -> 16'hFC00.
REQ-038 Subnormal: i_exp=1, mag=14'h1000 -> 16'h0200 with FP16_PACK_SUBNORMAL_EN, 16'h0000 without.
REQ-039 Back-to-back inputs 1.0, 2.0, 4.0 with i_ready low cycles 3-5 -> o_ready=0 while stalled; outputs 3C00, 4000, 4400 in order, none lost.
